// File: rtl/sha_pad_pkg.sv
// Shared types and constants for the SHA-256 message padder.
// Build option SHA_PAD_BSWAP_EN (little-endian host) is handled in sha_pad_last.
package sha_pad_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT,
    ST_DATA,
    ST_PAD80,
    ST_ZERO,
    ST_LENH,
    ST_LENL,
    ST_WAIT,
    ST_FIN
  } state_t;

  localparam logic [31:0] PAD_WORD  = 32'h8000_0000;
  localparam int          BLK_WORDS = 16;
  localparam int          LEN_IDX   = 14;

  // A byte count above a full word is treated as a full word.
  function automatic logic [2:0] clamp_bytes(input logic [2:0] n);
    return (n > 3'd4) ? 3'd4 : n;
  endfunction

endpackage

// File: rtl/sha_pad_last.sv
// Combinational word shaper: optional byte swap (SHA_PAD_BSWAP_EN) and
// construction of the padded final word (data bytes, 0x80 marker, zeros).
module sha_pad_last
  import sha_pad_pkg::*;
(
  input  logic [31:0] dat,
  input  logic [2:0]  bytes,
  output logic [31:0] word,
  output logic [31:0] padded
);

  always_comb begin
`ifdef SHA_PAD_BSWAP_EN
    // Little-endian host: after the swap its low-order valid bytes sit on top.
    word = {dat[7:0], dat[15:8], dat[23:16], dat[31:24]};
`else
    word = dat;
`endif
    case (clamp_bytes(bytes))
      3'd1:    padded = {word[31:24], 24'h80_0000};
      3'd2:    padded = {word[31:16], 16'h8000};
      3'd3:    padded = {word[31:8], 8'h80};
      3'd4:    padded = word;
      default: padded = PAD_WORD;
    endcase
  end

endmodule

// File: rtl/sha_pad.sv
// SHA-256 padder/feeder: streams message words, 0x80 marker, zero fill and the
// 64-bit bit length into sha_core one 512-bit block at a time. Option: SHA_PAD_BSWAP_EN.
module sha_pad
  import sha_pad_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        start,
  input  logic        msg_vld,
  input  logic [31:0] msg_dat,
  input  logic        msg_last,
  input  logic [2:0]  msg_bytes,
  output logic        msg_rdy,
  output logic        core_init,
  output logic        core_vld,
  output logic [31:0] core_din,
  input  logic        core_done,
  output logic        busy,
  output logic        pad_done
);

  state_t           state, state_nxt;
  state_t           resume, resume_nxt;
  logic [4:0]       word_idx, word_idx_nxt, idx_inc;
  logic [LEN_W-1:0] bit_len, bit_len_nxt;
  logic             final_blk, final_nxt;
  logic             emit;
  logic [31:0]      emit_dat;
  logic             vld_q;
  logic [31:0]      din_q;
  logic             xfer;
  logic [2:0]       nbytes;
  logic [31:0]      in_word, in_padded;
  logic [63:0]      len64;

  sha_pad_last u_last (
    .dat    (msg_dat),
    .bytes  (msg_bytes),
    .word   (in_word),
    .padded (in_padded)
  );

  assign nbytes    = clamp_bytes(msg_bytes);
  assign msg_rdy   = (state == ST_DATA) && (word_idx < 5'(BLK_WORDS));
  assign xfer      = msg_vld & msg_rdy;
  assign idx_inc   = word_idx + 5'd1;
  assign busy      = (state != ST_IDLE);
  assign core_init = (state == ST_INIT);
  assign pad_done  = (state == ST_FIN);
  assign core_vld  = vld_q;
  assign core_din  = din_q;

  always_comb begin
    len64              = '0;
    len64[LEN_W-1:0]   = bit_len;
  end

  // Where to go after emitting a padding word: block full, length slot, or more zeros.
  function automatic state_t after_pad(input logic [4:0] idx);
    if (idx == 5'(BLK_WORDS)) return ST_WAIT;
    if (idx == 5'(LEN_IDX))   return ST_LENH;
    return ST_ZERO;
  endfunction

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no branch infers a latch.
    state_nxt    = state;
    resume_nxt   = resume;
    final_nxt    = final_blk;
    word_idx_nxt = word_idx;
    bit_len_nxt  = bit_len;
    emit         = 1'b0;
    emit_dat     = '0;

    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_INIT;
      end

      ST_INIT: begin
        word_idx_nxt = '0;
        bit_len_nxt  = '0;
        final_nxt    = 1'b0;
        state_nxt    = ST_DATA;
      end

      ST_DATA: begin
        if (xfer) begin
          if (!msg_last) begin
            emit         = 1'b1;
            emit_dat     = in_word;
            word_idx_nxt = idx_inc;
            bit_len_nxt  = bit_len + LEN_W'(32);
            if (idx_inc == 5'(BLK_WORDS)) begin
              state_nxt  = ST_WAIT;
              resume_nxt = ST_DATA;
            end
          end else begin
            bit_len_nxt = bit_len + LEN_W'({nbytes, 3'b000});
            case (nbytes)
              3'd0: state_nxt = ST_PAD80;
              3'd4: begin
                emit         = 1'b1;
                emit_dat     = in_word;
                word_idx_nxt = idx_inc;
                resume_nxt   = ST_PAD80;
                state_nxt    = (idx_inc == 5'(BLK_WORDS)) ? ST_WAIT : ST_PAD80;
              end
              default: begin
                emit         = 1'b1;
                emit_dat     = in_padded;
                word_idx_nxt = idx_inc;
                resume_nxt   = ST_ZERO;
                state_nxt    = after_pad(idx_inc);
              end
            endcase
          end
        end
      end

      ST_PAD80: begin
        emit         = 1'b1;
        emit_dat     = PAD_WORD;
        word_idx_nxt = idx_inc;
        resume_nxt   = ST_ZERO;
        state_nxt    = after_pad(idx_inc);
      end

      ST_ZERO: begin
        if (word_idx == 5'(LEN_IDX)) begin
          state_nxt = ST_LENH;
        end else begin
          emit         = 1'b1;
          word_idx_nxt = idx_inc;
          resume_nxt   = ST_ZERO;
          state_nxt    = after_pad(idx_inc);
        end
      end

      ST_LENH: begin
        emit         = 1'b1;
        emit_dat     = len64[63:32];
        word_idx_nxt = idx_inc;
        state_nxt    = ST_LENL;
      end

      ST_LENL: begin
        emit         = 1'b1;
        emit_dat     = len64[31:0];
        word_idx_nxt = idx_inc;
        final_nxt    = 1'b1;
        state_nxt    = ST_WAIT;
      end

      ST_WAIT: begin
        if (core_done) begin
          word_idx_nxt = '0;
          state_nxt    = final_blk ? ST_FIN : resume;
        end
      end

      ST_FIN: begin
        final_nxt = 1'b0;
        state_nxt = ST_IDLE;
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    // NOTE: reset is synchronous; all state uses non-blocking assignments so every flop updates together.
    if (RST_I) begin
      state     <= ST_IDLE;
      resume    <= ST_IDLE;
      word_idx  <= '0;
      bit_len   <= '0;
      final_blk <= 1'b0;
      vld_q     <= 1'b0;
      din_q     <= '0;
    end else begin
      state     <= state_nxt;
      resume    <= resume_nxt;
      word_idx  <= word_idx_nxt;
      bit_len   <= bit_len_nxt;
      final_blk <= final_nxt;
      vld_q     <= emit;
      din_q     <= emit_dat;
    end
  end

endmodule

// File: tb/tb_sha_pad.sv
// Directed bench for sha_pad: feeds messages, models the core's done handshake,
// and compares the emitted word stream with an independently built padded message.
module tb_sha_pad;

  logic        CLK_I;
  logic        RST_I;
  logic        start;
  logic        msg_vld;
  logic [31:0] msg_dat;
  logic        msg_last;
  logic [2:0]  msg_bytes;
  logic        msg_rdy;
  logic        core_init;
  logic        core_vld;
  logic [31:0] core_din;
  logic        core_done;
  logic        busy;
  logic        pad_done;

  sha_pad #(.LEN_W(64)) dut (
    .CLK_I     (CLK_I),
    .RST_I     (RST_I),
    .start     (start),
    .msg_vld   (msg_vld),
    .msg_dat   (msg_dat),
    .msg_last  (msg_last),
    .msg_bytes (msg_bytes),
    .msg_rdy   (msg_rdy),
    .core_init (core_init),
    .core_vld  (core_vld),
    .core_din  (core_din),
    .core_done (core_done),
    .busy      (busy),
    .pad_done  (pad_done)
  );

  initial CLK_I = 1'b0;
  always #5 CLK_I = ~CLK_I;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  msg [0:127];
  logic [31:0] got [$];
  logic [31:0] exp_q [$];
  int          blk_words, wait_cnt, done_cnt, init_cnt, pdone_cnt;
  int          done_delay = 3;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] got_at(input int i);
    return (i < got.size()) ? got[i] : 32'hxxxx_xxxx;
  endfunction

  // Core stand-in: collects words and answers each 16-word block with a delayed done.
  initial begin
    core_done = 1'b0;
    forever begin
      @(negedge CLK_I);
      if (core_done) core_done = 1'b0;
      if (core_init) init_cnt++;
      if (pad_done)  pdone_cnt++;
      if (wait_cnt > 0) begin
        check("wait_core_vld", core_vld, 1'b0);
        check("wait_msg_rdy", msg_rdy, 1'b0);
        wait_cnt--;
        if (wait_cnt == 0) begin
          core_done = 1'b1;
          done_cnt++;
        end
      end
      if (core_vld) begin
        got.push_back(core_din);
        blk_words++;
        if (blk_words == 16) begin
          blk_words = 0;
          wait_cnt  = done_delay;
        end
      end
    end
  end

  task automatic clear_mon();
    got.delete();
    blk_words = 0;
    wait_cnt  = 0;
    done_cnt  = 0;
    init_cnt  = 0;
    pdone_cnt = 0;
  endtask

  task automatic fill_msg(input int len);
    for (int i = 0; i < len; i++) msg[i] = 8'(i * 7 + 3);
  endtask

  // Reference padding: message, 0x80, zeros to 56 mod 64, 64-bit big-endian bit length.
  task automatic build_exp(input int len);
    logic [7:0]  pb [$];
    logic [63:0] bl;
    exp_q.delete();
    for (int i = 0; i < len; i++) pb.push_back(msg[i]);
    pb.push_back(8'h80);
    while ((pb.size() % 64) != 56) pb.push_back(8'h00);
    bl = 64'(len) * 64'd8;
    for (int i = 7; i >= 0; i--) pb.push_back(bl[i*8 +: 8]);
    for (int w = 0; w < pb.size() / 4; w++)
      exp_q.push_back({pb[4*w], pb[4*w+1], pb[4*w+2], pb[4*w+3]});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge CLK_I); #1;
    start = 1'b0;
  endtask

  // Feed up to max_words words; unused bytes of a partial word carry junk when asked.
  task automatic send_words(input int len, input bit junk, input int bytes_ovr,
                            input int stray_at, input int max_words);
    int nwords, valid, guard;
    nwords = (len == 0) ? 1 : (len + 3) / 4;
    for (int w = 0; w < nwords && w < max_words; w++) begin
      if (w == stray_at) begin
        msg_vld = 1'b0;
        pulse_start();
        check("stray_start_busy", busy, 1'b1);
      end
      valid = (w == nwords - 1) ? (len - 4 * w) : 4;
      for (int b = 0; b < 4; b++)
        msg_dat[31 - 8*b -: 8] = (b < valid) ? msg[4*w + b] : (junk ? 8'hEE : 8'h00);
      msg_last  = (w == nwords - 1);
      msg_bytes = (msg_last && bytes_ovr >= 0) ? 3'(bytes_ovr) : 3'(valid);
      msg_vld   = 1'b1;
      guard = 0;
      do begin
        @(negedge CLK_I);
        guard++;
      end while (!msg_rdy && guard < 500);
      if (guard >= 500) check("rdy_timeout", 1'b0, 1'b1);
      @(posedge CLK_I); #1;
    end
    msg_vld  = 1'b0;
    msg_last = 1'b0;
  endtask

  task automatic run_msg(input string tag, input int len, input bit junk, input int bytes_ovr,
                         input int stray_at, input int delay, input int blocks);
    int guard;
    clear_mon();
    done_delay = delay;
    build_exp(len);
    pulse_start();
    send_words(len, junk, bytes_ovr, stray_at, 1000);
    guard = 0;
    while (!pad_done && guard < 3000) begin
      @(posedge CLK_I); #1;
      guard++;
    end
    check({tag, "_pad_done_seen"}, pad_done, 1'b1);
    @(posedge CLK_I); #1;
    check({tag, "_pad_done_1cyc"}, pad_done, 1'b0);
    check({tag, "_idle"}, busy, 1'b0);
    check({tag, "_init_cnt"}, 64'(init_cnt), 64'd1);
    check({tag, "_pdone_cnt"}, 64'(pdone_cnt), 64'd1);
    check({tag, "_blocks"}, 64'(done_cnt), 64'(blocks));
    check({tag, "_nwords"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_w%0d", tag, i), got_at(i), exp_q[i]);
  endtask

  initial begin
    RST_I = 1'b1; start = 1'b0; msg_vld = 1'b0; msg_dat = '0;
    msg_last = 1'b0; msg_bytes = '0;
    clear_mon();
    repeat (3) @(posedge CLK_I);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_msg_rdy", msg_rdy, 1'b0);
    check("rst_core_vld", core_vld, 1'b0);
    check("rst_core_din", core_din, 32'h0);
    check("rst_core_init", core_init, 1'b0);
    check("rst_pad_done", pad_done, 1'b0);
    RST_I = 1'b0;
    @(posedge CLK_I); #1;

    // "abc": single block, hand values for first and last word
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    run_msg("abc", 3, 1'b0, -1, -1, 3, 1);
    check("abc_first", got_at(0), 32'h6162_6380);
    check("abc_len", got_at(15), 32'h0000_0018);

    run_msg("empty", 0, 1'b0, -1, -1, 3, 1);
    check("empty_first", got_at(0), 32'h8000_0000);

    fill_msg(7);
    run_msg("b7_junk", 7, 1'b1, -1, -1, 2, 1);
    check("b7_partial", got_at(1), {msg[4], msg[5], msg[6], 8'h80});

    fill_msg(4);
    run_msg("b4_ovr7", 4, 1'b0, 7, -1, 2, 1);
    check("b4_len", got_at(15), 32'h0000_0020);

    fill_msg(55);
    run_msg("b55", 55, 1'b1, -1, -1, 2, 1);

    fill_msg(56);
    run_msg("b56", 56, 1'b0, -1, 3, 4, 2);
    check("b56_pad80", got_at(14), 32'h8000_0000);
    check("b56_len", got_at(31), 32'h0000_01C0);

    fill_msg(57);
    run_msg("b57", 57, 1'b1, -1, -1, 3, 2);

    fill_msg(64);
    run_msg("b64", 64, 1'b0, -1, -1, 20, 2);
    check("b64_pad80", got_at(16), 32'h8000_0000);
    check("b64_len", got_at(31), 32'h0000_0200);

    fill_msg(70);
    run_msg("b70_slow", 70, 1'b0, -1, -1, 20, 2);

    // Reset in the middle of the first block
    clear_mon();
    fill_msg(40);
    pulse_start();
    send_words(40, 1'b0, -1, -1, 7);
    RST_I = 1'b1;
    @(posedge CLK_I); #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_core_vld", core_vld, 1'b0);
    check("midrst_msg_rdy", msg_rdy, 1'b0);
    RST_I = 1'b0;
    @(posedge CLK_I); #1;

    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    run_msg("abc_after_rst", 3, 1'b0, -1, -1, 3, 1);
    check("abc2_first", got_at(0), 32'h6162_6380);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
